// File: rtl/ysyx_23060184_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_ifu_pkg
// Purpose  : Shared widths, reset PC, bus response code and fetch FSM states
//            for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060184_ifu_pkg;

  localparam int          IFU_DATA_WIDTH = 32;
  localparam int          IFU_ADDR_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AR     = 3'd1,
    S_R      = 3'd2,
    S_HOLD   = 3'd3,
    S_WAITPC = 3'd4,
    S_ERR    = 3'd5
  } ifu_state_t;

  // Instructions are word aligned; anything else is a fetch fault
  function automatic logic addr_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060184_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_pc_reg
// Purpose  : PC register with a registered PC+4 companion, so neither value
//            has an adder on its output path.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_pc_reg #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_plus4;

  // Load PC and its successor together; the +4 wraps modulo 2^ADDR_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_pc_plus4 <= RESET_PC + ADDR_WIDTH'(4);
    end else if (load) begin
      r_pc       <= next_pc;
      r_pc_plus4 <= next_pc + ADDR_WIDTH'(4);
    end
  end

  assign pc       = r_pc;
  assign pc_plus4 = r_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060184_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_ifu
// Purpose  : Instruction-fetch stage. Fetches one instruction per
//            architectural step over an AXI-lite style read channel, hands it
//            to decode, then waits for writeback to supply the next PC.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_ifu
  import ysyx_23060184_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  // read address channel
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  // decode interface
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  output logic                  Ivalid,
  input  logic                  Dready,
  // writeback interface
  input  logic                  Wvalid,
  input  logic [ADDR_WIDTH-1:0] NextPC,
  // status
  output logic                  fetch_err,
  output logic [31:0]           fetch_cnt
);

  ifu_state_t            r_state;
  ifu_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [31:0]           r_fetch_cnt;
  logic                  w_load_pc;
  logic                  w_inst_take;
  logic                  w_accept;

  assign w_load_pc   = (r_state == S_WAITPC) && Wvalid;
  assign w_inst_take = (r_state == S_R) && rvalid && (rresp == RESP_OKAY);
  assign w_accept    = (r_state == S_HOLD) && Dready;

  // PC is redirected only by writeback; a misaligned target is still
  // captured so the faulting address is visible for debug
  ysyx_23060184_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load_pc),
    .next_pc  (NextPC),
    .pc       (pc),
    .pc_plus4 (PCPlus4)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; ERR is terminal until reset
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_AR;
      S_AR:     if (arready) w_next_state = S_R;
      S_R: begin
        if (rvalid) begin
          w_next_state = (rresp == RESP_OKAY) ? S_HOLD : S_ERR;
        end
      end
      S_HOLD:   if (Dready) w_next_state = S_WAITPC;
      S_WAITPC: begin
        if (Wvalid) begin
          w_next_state = addr_aligned(NextPC[1:0]) ? S_AR : S_ERR;
        end
      end
      S_ERR:    w_next_state = S_ERR;
      default:  w_next_state = S_ERR;
    endcase
  end

  // Capture the instruction on a good read response; held through HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst <= '0;
    end else if (w_inst_take) begin
      r_inst <= rdata;
    end
  end

  // Count instructions accepted by decode; wraps silently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
    end else if (w_accept) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  // Handshake outputs decode straight from the state register
  assign araddr    = pc;
  assign arvalid   = (r_state == S_AR);
  assign rready    = (r_state == S_R);
  assign Ivalid    = (r_state == S_HOLD);
  assign fetch_err = (r_state == S_ERR);
  assign inst      = r_inst;
  assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire
